// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcode field and fetch FSM state for the 8-bit CPU.
package cpu_pkg;
  localparam int ADDR_W = 8;
  localparam int INSTR_W = 16;
  localparam logic [3:0] OP_HLT = 4'h4;
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} fetch_state_t;
  function automatic logic [3:0] opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: imem address/data, pipeline control and IF/ID outputs of the fetch stage.
interface instruction_fetch_unit_if;
  import cpu_pkg::*;
  logic [ADDR_W-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic stall;
  logic redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic halt_retired;
  logic ifid_valid;
  logic [INSTR_W-1:0] ifid_instr;
  logic [ADDR_W-1:0] ifid_pc;
  logic [ADDR_W-1:0] ifid_pc_plus1;
  logic halted;
  modport master (
    output imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus1, halted,
    input imem_instr, stall, redirect_valid, redirect_pc, halt_retired
  );
  modport slave (
    input imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus1, halted,
    output imem_instr, stall, redirect_valid, redirect_pc, halt_retired
  );
endinterface

// File: rtl/instruction_fetch_unit_pc_reg.sv
// pc_reg: program counter with load (priority), increment and hold, sync reset to RESET_PC.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_pc_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  always_comb pc_d = load_i ? load_pc_i : inc_i ? pc_q + ADDR_W'(1) : pc_q;
  always_ff @(posedge clk) pc_q <= rst ? RESET_PC : pc_d;
  assign pc_o = pc_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, fills IF/ID from combinational imem, and stops fetching at HLT.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [3:0]        HALT_OPCODE = OP_HLT
) (
  input logic                      clk,
  input logic                      rst,
  instruction_fetch_unit_if.master fetch_if
);
  fetch_state_t state_q;
  logic [ADDR_W-1:0] pc, pc_plus1, ifid_pc_q, ifid_pc_plus1_q;
  logic [INSTR_W-1:0] ifid_instr_q;
  logic ifid_valid_q, halted_q, is_hlt, load, inc;
  assign pc_plus1 = pc + ADDR_W'(1);
  assign is_hlt = opcode(fetch_if.imem_instr) == HALT_OPCODE;
  // a retiring HLT in DRAIN wins over a same-cycle redirect, so the PC must not load then
  assign load = fetch_if.redirect_valid &&
                (state_q == RUN || (state_q == DRAIN && !fetch_if.halt_retired));
  assign inc = state_q == RUN && !fetch_if.redirect_valid && !fetch_if.stall && !is_hlt;
  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .load_pc_i(fetch_if.redirect_pc),
    .inc_i    (inc),
    .pc_o     (pc)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      ifid_valid_q    <= 1'b0;
      ifid_instr_q    <= '0;
      ifid_pc_q       <= '0;
      ifid_pc_plus1_q <= '0;
      halted_q        <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (fetch_if.redirect_valid) ifid_valid_q <= 1'b0;
          else if (!fetch_if.stall) begin
            ifid_valid_q    <= 1'b1;
            ifid_instr_q    <= fetch_if.imem_instr;
            ifid_pc_q       <= pc;
            ifid_pc_plus1_q <= pc_plus1;
            if (is_hlt) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (fetch_if.halt_retired) begin
            state_q      <= HALTED;
            halted_q     <= 1'b1;
            ifid_valid_q <= 1'b0;
          end else if (fetch_if.redirect_valid) begin
            state_q      <= RUN;
            ifid_valid_q <= 1'b0;
          end else if (!fetch_if.stall) ifid_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
  assign fetch_if.imem_addr     = pc;
  assign fetch_if.ifid_valid    = ifid_valid_q;
  assign fetch_if.ifid_instr    = ifid_instr_q;
  assign fetch_if.ifid_pc       = ifid_pc_q;
  assign fetch_if.ifid_pc_plus1 = ifid_pc_plus1_q;
  assign fetch_if.halted        = halted_q;
endmodule
